// File: rtl/afe_spi_pkg.sv
// Shared types and sizing helpers for the AFE SPI arbiter and its shift engine.
package afe_spi_pkg;

  // Sequencing of one SPI word: clock out all bits, settle, pulse LE, acknowledge.
  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LE_SETUP,
    LE_PULSE,
    DONE
  } afe_state_e;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Half-period counter runs 0..CLK_DIV-1.
  function automatic int half_cnt_w(input int clk_div);
    return cnt_w(clk_div);
  endfunction

  // Bit counter is sized to hold DATA_WIDTH itself.
  function automatic int bit_cnt_w(input int data_width);
    return cnt_w(data_width + 1);
  endfunction

  // LE counter is sized to hold LE_WIDTH itself.
  function automatic int le_cnt_w(input int le_width);
    return cnt_w(le_width + 1);
  endfunction

  // Requester index width.
  function automatic int idx_w(input int num_req);
    return cnt_w(num_req);
  endfunction

endpackage

// File: rtl/afe_spi_shifter.sv
// Single-word SPI engine: loads a word, clocks it out MSB-first with H-cycle
// half-periods, waits one half-period, pulses LE and flags completion.
// The *_o signals other than idle_o are the values for the NEXT cycle; the
// top level registers them into the granted channel so every pin is a flop.
module afe_spi_shifter
  import afe_spi_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int CLK_DIV    = 16,
  parameter int LE_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  idle_o,
  output logic                  busy_o,
  output logic                  sclk_o,
  output logic                  sdi_o,
  output logic                  le_o,
  output logic                  done_o
);

  localparam int HW  = half_cnt_w(CLK_DIV);
  localparam int BW  = bit_cnt_w(DATA_WIDTH);
  localparam int LEW = le_cnt_w(LE_WIDTH);

  localparam logic [HW-1:0]  HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [LEW-1:0] LE_LAST   = LEW'(LE_WIDTH - 1);

  afe_state_e            state_q, state_d;
  logic [HW-1:0]         half_cnt_q, half_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [LEW-1:0]        le_cnt_q, le_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  half_tc;

  assign half_tc = (half_cnt_q == HALF_LAST);

  // State, counters and shift register; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      le_cnt_q   <= '0;
      shreg_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      le_cnt_q   <= le_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  // Next-state sequencing; counters reload to 0 at their terminal count.
  always_comb begin
    // NOTE: hold-current defaults first, so no path through this block infers a latch.
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    le_cnt_d   = le_cnt_q;
    shreg_d    = shreg_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          shreg_d    = data_i;
          half_cnt_d = '0;
          bit_cnt_d  = '0;
          le_cnt_d   = '0;
          state_d    = SHIFT_LO;
        end
      end

      SHIFT_LO: begin
        if (half_tc) begin
          half_cnt_d = '0;
          state_d    = SHIFT_HI;
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end

      SHIFT_HI: begin
        if (half_tc) begin
          half_cnt_d = '0;
          shreg_d    = {shreg_q[DATA_WIDTH-2:0], 1'b0};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = LE_SETUP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = SHIFT_LO;
          end
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end

      LE_SETUP: begin
        if (half_tc) begin
          half_cnt_d = '0;
          le_cnt_d   = '0;
          state_d    = LE_PULSE;
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end

      LE_PULSE: begin
        if (le_cnt_q == LE_LAST) begin
          le_cnt_d = '0;
          state_d  = DONE;
        end else begin
          le_cnt_d = le_cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin values for the cycle that follows the coming edge.
  // SDI carries the MSB through both clock phases so it is stable around the rise.
  assign idle_o = (state_q == IDLE);
  assign busy_o = (state_d != IDLE);
  assign sclk_o = (state_d == SHIFT_HI);
  assign sdi_o  = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) && shreg_d[DATA_WIDTH-1];
  assign le_o   = (state_d == LE_PULSE);
  assign done_o = (state_d == DONE);

endmodule

// File: rtl/afe_spi_arbiter.sv
// Round-robin share of one SPI shift engine between NUM_REQ AFE channels.
// The granted requester's word is clocked onto its own CLK/SDI/LE pins; all
// other channels are held at 0. Every output comes straight from a flop.
module afe_spi_arbiter
  import afe_spi_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 24,
  parameter int CLK_DIV    = 16,
  parameter int LE_WIDTH   = 8
) (
  input  logic                          sysClk,
  input  logic                          sysReset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          busy,
  output logic [NUM_REQ-1:0]            AFE_SPI_CLK,
  output logic [NUM_REQ-1:0]            AFE_SPI_SDI,
  output logic [NUM_REQ-1:0]            AFE_SPI_LE
);

  localparam int IW = idx_w(NUM_REQ);

  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         pick;
  logic                  found;
  logic [DATA_WIDTH-1:0] load_word;
  logic                  start;
  logic [NUM_REQ-1:0]    chan_sel;

  logic sh_idle, busy_nxt, sclk_nxt, sdi_nxt, le_nxt, done_nxt;

  logic [NUM_REQ-1:0] ack_q, spi_clk_q, spi_sdi_q, spi_le_q;
  logic               busy_q;

  // First asserted request at or after the pointer, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign load_word = DATA_WIDTH'(reqData >> (int'(pick) * DATA_WIDTH));
  assign start     = sh_idle && found;

  // Grant and pointer only move when the engine is free and someone is asking.
  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (start) begin
      grant_d = pick;
      ptr_d   = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
    end
  end

  // Arbiter state.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  afe_spi_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLK_DIV    (CLK_DIV),
    .LE_WIDTH   (LE_WIDTH)
  ) u_shifter (
    .clk     (sysClk),
    .rst_n   (sysReset_n),
    .start_i (start),
    .data_i  (load_word),
    .idle_o  (sh_idle),
    .busy_o  (busy_nxt),
    .sclk_o  (sclk_nxt),
    .sdi_o   (sdi_nxt),
    .le_o    (le_nxt),
    .done_o  (done_nxt)
  );

  // One-hot of the channel owning the next cycle, so the demux uses the new grant.
  assign chan_sel = NUM_REQ'(1) << grant_d;

  // Per-channel output demux registers; reset drops every pin at once.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      ack_q     <= '0;
      busy_q    <= 1'b0;
      spi_clk_q <= '0;
      spi_sdi_q <= '0;
      spi_le_q  <= '0;
    end else begin
      ack_q     <= done_nxt ? chan_sel : '0;
      busy_q    <= busy_nxt;
      spi_clk_q <= sclk_nxt ? chan_sel : '0;
      spi_sdi_q <= sdi_nxt  ? chan_sel : '0;
      spi_le_q  <= le_nxt   ? chan_sel : '0;
    end
  end

  assign ack         = ack_q;
  assign busy        = busy_q;
  assign AFE_SPI_CLK = spi_clk_q;
  assign AFE_SPI_SDI = spi_sdi_q;
  assign AFE_SPI_LE  = spi_le_q;

endmodule

// File: tb/tb_afe_spi_arbiter.sv
// Bench for afe_spi_arbiter: directed scenarios plus a randomized phase, all
// compared every cycle against a transfer-level timing model of the pins.
module tb_afe_spi_arbiter;

  localparam int NR        = 2;
  localparam int DW        = 16;
  localparam int CD        = 4;
  localparam int LW        = 4;
  localparam int CW        = (NR > 1) ? $clog2(NR) : 1;
  localparam int SHIFT_CYC = 2 * CD * DW;
  localparam int XFER      = SHIFT_CYC + CD + LW + 1;   // 137 cycles, grant to ack inclusive

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic [NR-1:0]     req      = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     ack;
  logic              busy;
  logic [NR-1:0]     spi_clk, spi_sdi, spi_le;

  afe_spi_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .CLK_DIV    (CD),
    .LE_WIDTH   (LW)
  ) dut (
    .sysClk      (clk),
    .sysReset_n  (rst_n),
    .req         (req),
    .reqData     (req_data),
    .ack         (ack),
    .busy        (busy),
    .AFE_SPI_CLK (spi_clk),
    .AFE_SPI_SDI (spi_sdi),
    .AFE_SPI_LE  (spi_le)
  );

  always #5 clk = ~clk;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  // Reference model: one active transfer described by its start cycle, channel and word.
  int            m_ptr     = 0;
  int            m_start   = -1000;
  int            m_chan    = 0;
  int            m_free_at = 0;
  logic [DW-1:0] m_word    = '0;

  // Receiver side: what each channel's pins actually delivered.
  logic [DW-1:0] cap   [NR];
  int            nbits [NR];
  int            nle   [NR];
  logic [NR-1:0] clk_prev = '0;

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
      if (failures >= 200) begin
        summary();
        $finish;
      end
    end
  endtask

  // Expected {busy, ack, le, sdi, clk} for the current cycle, from transfer timing rules.
  function automatic logic [8:0] model_pins();
    int            t;
    int            bitn;
    logic [NR-1:0] sel;
    logic [8:0]    e;
    e = '0;
    t = cyc - m_start;
    if (t >= 0 && t < XFER) begin
      sel  = NR'(1) << m_chan;
      e[8] = 1'b1;
      if (t < SHIFT_CYC) begin
        bitn = t / (2 * CD);
        if ((t % (2 * CD)) >= CD) e[1:0] = sel;
        if (((m_word >> (DW - 1 - bitn)) & 1) != 0) e[3:2] = sel;
      end else if (t < SHIFT_CYC + CD) begin
        e = e;
      end else if (t < XFER - 1) begin
        e[5:4] = sel;
      end else begin
        e[7:6] = sel;
      end
    end
    return e;
  endfunction

  task automatic clear_rx();
    for (int n = 0; n < NR; n++) begin
      cap[CW'(n)]   = '0;
      nbits[CW'(n)] = 0;
      nle[CW'(n)]   = 0;
    end
  endtask

  // Per-cycle monitor step, run just after each rising edge.
  task automatic step();
    logic [8:0]    obs;
    logic [NR-1:0] sel;
    int            c;
    cyc++;
    obs = {busy, ack, spi_le, spi_sdi, spi_clk};
    if (!rst_n) begin
      m_ptr     = 0;
      m_start   = -1000;
      m_free_at = 0;
      clear_rx();
      clk_prev  = '0;
      check("reset_pins", 32'(obs), 32'(0));
      return;
    end
    if (cyc >= m_free_at && req != '0) begin
      c = m_ptr;
      while (((req >> c) & 1) == 0) c = (c + 1) % NR;
      m_chan    = c;
      m_word    = DW'(req_data >> (c * DW));
      m_start   = cyc;
      m_free_at = cyc + XFER + 1;
      m_ptr     = (c + 1) % NR;
    end
    check("pins", 32'(obs), 32'(model_pins()));
    for (int n = 0; n < NR; n++) begin
      sel = NR'(1) << n;
      if ((spi_clk & sel) != 0 && (clk_prev & sel) == 0) begin
        cap[CW'(n)] = {cap[CW'(n)][DW-2:0], (spi_sdi & sel) != 0};
        nbits[CW'(n)]++;
      end
      if ((spi_le & sel) != 0) nle[CW'(n)]++;
      if ((ack & sel) != 0) begin
        check("ack_chan", 32'(n), 32'(m_chan));
        check("rx_word", 32'(cap[CW'(n)]), 32'(m_word));
        check("rx_bits", 32'(nbits[CW'(n)]), 32'(DW));
        check("le_len", 32'(nle[CW'(n)]), 32'(LW));
        check("ack_latency", 32'(cyc - m_start + 1), 32'(XFER));
        cap[CW'(n)]   = '0;
        nbits[CW'(n)] = 0;
        nle[CW'(n)]   = 0;
      end
    end
    clk_prev = spi_clk;
  endtask

  initial begin
    clear_rx();
    forever begin
      @(posedge clk);
      #1;
      step();
    end
  end

  // Wait (bounded) for any ack, then compare which requester it was for.
  task automatic wait_ack(input logic [NR-1:0] exp_ack, input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ack == '0 && k < 3 * XFER);
    check(tag, 32'(ack), 32'(exp_ack));
  endtask

  task automatic wait_busy(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!busy && k < 10);
    check(tag, 32'(busy), 32'(1));
  endtask

  initial begin
    int k;
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single request on channel 0.
    @(negedge clk);
    req_data[DW-1:0] = 16'hA5C3;
    req              = 2'b01;
    wait_ack(2'b01, "single_ack");
    req = '0;
    @(negedge clk);

    // Both requesting straight out of reset: 0, gap, 1, then 0 again.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    req_data = {16'h3C5A, 16'h0FF0};
    req      = 2'b11;
    rst_n    = 1'b1;
    wait_ack(2'b01, "sim_first0");
    @(negedge clk);
    check("sim_gap_idle", 32'(busy), 32'(0));
    @(negedge clk);
    check("sim_grant1", 32'(busy), 32'(1));
    wait_ack(2'b10, "sim_then1");
    wait_ack(2'b01, "sim_alt0");
    req = '0;
    @(negedge clk);

    // Pointer rotation: serve 1 alone, then a tie goes to 0.
    req = 2'b10;
    wait_ack(2'b10, "rot_serve1");
    req = '0;
    @(negedge clk);
    req = 2'b11;
    wait_ack(2'b01, "rot_first0");
    req = '0;
    @(negedge clk);

    // Data and request changes after grant are ignored.
    req_data[DW-1:0] = 16'h1234;
    req              = 2'b01;
    wait_busy("chg_grant");
    repeat (20) @(negedge clk);
    req_data[DW-1:0] = 16'hFFFF;
    req              = '0;
    wait_ack(2'b01, "chg_ack0");
    @(negedge clk);

    // Reset mid-transfer clears pins without a clock, then pointer restarts at 0.
    req_data[DW-1:0] = 16'h8001;
    req              = 2'b01;
    wait_busy("rst_grant");
    repeat (49) @(negedge clk);
    check("mid_busy", 32'(busy), 32'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("async_clear", 32'({busy, ack, spi_le, spi_sdi, spi_clk}), 32'(0));
    repeat (3) @(negedge clk);
    req_data = {16'h5AA5, 16'h6DB6};
    req      = 2'b11;
    rst_n    = 1'b1;
    wait_ack(2'b01, "post_rst_first0");
    req = 2'b10;
    wait_ack(2'b10, "post_rst_req1");
    req = '0;
    @(negedge clk);

    // Held request: a second transfer follows after exactly one idle cycle.
    req_data[DW-1:0] = 16'hC0DE;
    req              = 2'b01;
    wait_ack(2'b01, "held_first");
    @(negedge clk);
    check("held_gap_idle", 32'(busy), 32'(0));
    @(negedge clk);
    check("held_regrant", 32'(busy), 32'(1));
    wait_ack(2'b01, "held_second");
    req = '0;

    // Randomized requests, data churn and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) req = req ^ (NR'(1) << $urandom_range(0, NR - 1));
      if ($urandom_range(0, 7) == 0) req_data = $urandom;
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end

    req = '0;
    k   = 0;
    while (busy && k < XFER + 5) begin
      @(negedge clk);
      k++;
    end
    check("drain_idle", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);
    summary();
    $finish;
  end

  initial begin
    #500000;
    checks++;
    failures++;
    $display("FAIL watchdog: run still active at cycle %0d, expected completion", cyc);
    summary();
    $finish;
  end

endmodule
